// File: rtl/dmem_pkg.sv
// dmem_pkg: store width encodings and MMIO register offsets
// shared by the data-memory responder and its console FIFO.
package dmem_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    localparam logic [4:0] OFF_CON_TX   = 5'h00;
    localparam logic [4:0] OFF_CON_STAT = 5'h04;
    localparam logic [4:0] OFF_TOHOST   = 5'h08;
    localparam logic [4:0] OFF_CYC_LO   = 5'h0C;
    localparam logic [4:0] OFF_CYC_HI   = 5'h10;

    localparam logic [31:0] MMIO_SPAN = 32'h20;

endpackage

// File: rtl/dmem_responder_con_fifo.sv
// con_fifo: byte-wide console TX FIFO; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module con_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    push,
    input  logic [7:0]              push_data,
    input  logic                    pop,
    output logic [7:0]              head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push_en;
    logic          pop_en;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (srst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_en)
                wptr <= wptr + 1'b1;
            if (pop_en)
                rptr <= rptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_en)
            mem[wptr] <= push_data;
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: RAM plus console/tohost/cycle-counter MMIO behind the
// core dmem port. DMEM_CYCLE_CNT_EN enables the 64-bit cycle counter.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_LEN  = 14,
    parameter int          CON_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        c_srst,
    input  logic        c_dmem_load,
    input  logic [31:0] dmem_load_addr,
    output logic [31:0] dmem_load_data,
    input  logic        c_dmem_store,
    input  logic [31:0] dmem_store_addr,
    input  logic [1:0]  dmem_store_width,
    input  logic [31:0] dmem_store_data,
    output logic [7:0]  con_data,
    output logic        c_con_valid,
    input  logic        c_con_ready,
    output logic        c_halt,
    output logic [30:0] exit_code,
    output logic        c_misalign,
    output logic        c_con_ovf
);

    localparam int          CW      = $clog2(CON_DEPTH) + 1;
    localparam int          WORDS   = 2 ** (ADDR_LEN - 2);
    localparam logic [31:0] RAM_TOP = 32'(1) << ADDR_LEN;

    logic [31:0]   ram [WORDS];
    logic [31:0]   ld_off;
    logic [31:0]   st_off;
    logic          ld_ram;
    logic          ld_mmio;
    logic          st_ram;
    logic          st_mmio;
    logic          st_misalign;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic [31:0]   mmio_rdata;
    logic [31:0]   cyc_lo;
    logic [31:0]   cyc_hi;
    logic [CW-1:0] con_count;
    logic          con_push;
    logic          con_pop;
    logic          con_full;
    logic          con_empty;
    logic          tohost_wr;

    assign ld_off  = (dmem_load_addr & ~32'h3) - MMIO_BASE;
    assign ld_ram  = dmem_load_addr < RAM_TOP;
    assign ld_mmio = ld_off < MMIO_SPAN;
    assign st_off  = dmem_store_addr - MMIO_BASE;
    assign st_ram  = dmem_store_addr < RAM_TOP;

    always_comb begin
        mmio_rdata = '0;
        case (ld_off[4:0])
            OFF_CON_STAT: mmio_rdata = 32'(con_count);
            OFF_CYC_LO:   mmio_rdata = cyc_lo;
            OFF_CYC_HI:   mmio_rdata = cyc_hi;
            default:      ;
        endcase
    end

    always_comb begin
        dmem_load_data = '0;
        if (c_dmem_load) begin
            if (ld_ram)
                dmem_load_data = ram[dmem_load_addr[ADDR_LEN-1:2]];
            else if (ld_mmio)
                dmem_load_data = mmio_rdata;
        end
    end

    // Lane enables and lane-replicated write data per store width.
    always_comb begin
        st_be       = '0;
        st_wdata    = dmem_store_data;
        st_misalign = 1'b0;
        unique case (1'b1)
            dmem_store_width == W_BYTE: begin
                st_be    = 4'b0001 << dmem_store_addr[1:0];
                st_wdata = {4{dmem_store_data[7:0]}};
            end
            dmem_store_width == W_HALF: begin
                st_misalign = dmem_store_addr[0];
                st_be    = dmem_store_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{dmem_store_data[15:0]}};
            end
            dmem_store_width == W_WORD: begin
                st_misalign = dmem_store_addr[1:0] != 2'b00;
                st_be       = 4'b1111;
            end
            default: ;
        endcase
        if (!c_dmem_store || st_misalign)
            st_be = '0;
    end

    assign st_mmio   = c_dmem_store && !st_misalign &&
                       dmem_store_width == W_WORD &&
                       st_off < MMIO_SPAN;
    assign tohost_wr = st_mmio && st_off[4:0] == OFF_TOHOST;
    assign con_push  = st_mmio && st_off[4:0] == OFF_CON_TX && !c_srst;
    assign con_pop   = c_con_valid & c_con_ready;

    // RAM writes ignore reset so a store issued alongside reset lands.
    always_ff @(posedge clk) begin
        if (st_ram) begin
            for (int i = 0; i < 4; i++)
                if (st_be[i])
                    ram[dmem_store_addr[ADDR_LEN-1:2]][8*i +: 8]
                        <= st_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (c_srst) begin
            c_halt     <= 1'b0;
            exit_code  <= '0;
            c_misalign <= 1'b0;
            c_con_ovf  <= 1'b0;
        end else begin
            c_misalign <= c_dmem_store & st_misalign;
            if (con_push & con_full & ~con_pop)
                c_con_ovf <= 1'b1;
            if (tohost_wr) begin
                exit_code <= dmem_store_data[31:1];
                c_halt    <= c_halt | dmem_store_data[0];
            end
        end
    end

`ifdef DMEM_CYCLE_CNT_EN
    logic [63:0] cyc_cnt;
    logic [31:0] cyc_shadow;
    logic        cyc_lo_rd;

    assign cyc_lo_rd = c_dmem_load && !ld_ram && ld_mmio &&
                       ld_off[4:0] == OFF_CYC_LO;

    always_ff @(posedge clk) begin
        if (c_srst) begin
            cyc_cnt    <= '0;
            cyc_shadow <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 64'd1;
            if (cyc_lo_rd)
                cyc_shadow <= cyc_cnt[63:32];
        end
    end

    assign cyc_lo = cyc_cnt[31:0];
    assign cyc_hi = cyc_shadow;
`else
    assign cyc_lo = '0;
    assign cyc_hi = '0;
`endif

    con_fifo #(
        .DEPTH(CON_DEPTH)
    ) u_con_fifo (
        .clk      (clk),
        .srst     (c_srst),
        .push     (con_push),
        .push_data(dmem_store_data[7:0]),
        .pop      (con_pop),
        .head     (con_data),
        .count    (con_count),
        .full     (con_full),
        .empty    (con_empty)
    );

    assign c_con_valid = ~con_empty;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for RAM loads/stores, console
// FIFO, tohost and the cycle counter (DMEM_CYCLE_CNT_EN aware).
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam logic [31:0] MB = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        c_srst;
    logic        c_dmem_load;
    logic [31:0] dmem_load_addr;
    logic [31:0] dmem_load_data;
    logic        c_dmem_store;
    logic [31:0] dmem_store_addr;
    logic [1:0]  dmem_store_width;
    logic [31:0] dmem_store_data;
    logic [7:0]  con_data;
    logic        c_con_valid;
    logic        c_con_ready;
    logic        c_halt;
    logic [30:0] exit_code;
    logic        c_misalign;
    logic        c_con_ovf;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] ld_q[$];
    logic [7:0]  con_q[$];
    int          m_cnt = 0;
    logic        m_ovf = 1'b0;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk             (clk),
        .c_srst          (c_srst),
        .c_dmem_load     (c_dmem_load),
        .dmem_load_addr  (dmem_load_addr),
        .dmem_load_data  (dmem_load_data),
        .c_dmem_store    (c_dmem_store),
        .dmem_store_addr (dmem_store_addr),
        .dmem_store_width(dmem_store_width),
        .dmem_store_data (dmem_store_data),
        .con_data        (con_data),
        .c_con_valid     (c_con_valid),
        .c_con_ready     (c_con_ready),
        .c_halt          (c_halt),
        .exit_code       (exit_code),
        .c_misalign      (c_misalign),
        .c_con_ovf       (c_con_ovf)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Console consumer: each accepted pop is compared with the queue head.
    always @(negedge clk) begin
        if (!c_srst && c_con_valid && c_con_ready) begin
            check("con_pop_expected", 64'(con_q.size() != 0), 64'd1);
            if (con_q.size() != 0)
                check("con_data", 64'(con_data), 64'(con_q.pop_front()));
        end
    end

    task automatic store(input logic [31:0] a, input logic [1:0] w,
                         input logic [31:0] d);
        c_dmem_store     = 1'b1;
        dmem_store_addr  = a;
        dmem_store_width = w;
        dmem_store_data  = d;
        @(posedge clk);
        #1;
        c_dmem_store = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [31:0] a,
                            input logic [31:0] e);
        c_dmem_load    = 1'b1;
        dmem_load_addr = a;
        ld_q.push_back(e);
        @(negedge clk);
        check(tag, 64'(dmem_load_data), 64'(ld_q.pop_front()));
        @(posedge clk);
        #1;
        c_dmem_load = 1'b0;
    endtask

    task automatic con_push(input logic [7:0] b, input logic rdy);
        logic pop_now;
        pop_now     = rdy && m_cnt > 0;
        c_con_ready = rdy;
        if (m_cnt < 4 || pop_now) begin
            con_q.push_back(b);
            m_cnt++;
        end else begin
            m_ovf = 1'b1;
        end
        if (pop_now)
            m_cnt--;
        store(MB, W_WORD, 32'(b));
        c_con_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        c_con_ready = 1'b1;
        while (c_con_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_valid"}, 64'(c_con_valid), 64'd0);
        check({tag, "_left"}, 64'(con_q.size()), 64'd0);
        c_con_ready = 1'b0;
        m_cnt       = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        c_srst           = 1'b1;
        c_dmem_load      = 1'b0;
        dmem_load_addr   = '0;
        c_dmem_store     = 1'b0;
        dmem_store_addr  = '0;
        dmem_store_width = W_WORD;
        dmem_store_data  = '0;
        c_con_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        c_srst = 1'b0;

        check("rst_halt", 64'(c_halt), 64'd0);
        check("rst_exit", 64'(exit_code), 64'd0);
        check("rst_mis", 64'(c_misalign), 64'd0);
        check("rst_ovf", 64'(c_con_ovf), 64'd0);
        check("rst_valid", 64'(c_con_valid), 64'd0);

        store(32'h100, W_WORD, 32'hDEAD_BEEF);
        store(32'h102, W_BYTE, 32'h0000_0055);
        load_chk("ld100", 32'h100, 32'hDE55_BEEF);
        load_chk("ld103", 32'h103, 32'hDE55_BEEF);

        store(32'h200, W_WORD, 32'h1122_3344);
        store(32'h202, W_HALF, 32'h9999_ABCD);
        load_chk("half_hi", 32'h200, 32'hABCD_3344);

        store(32'h201, W_HALF, 32'h0000_FFFF);
        check("mis_half_pulse", 64'(c_misalign), 64'd1);
        load_chk("mis_half_ram", 32'h200, 32'hABCD_3344);
        check("mis_half_clr", 64'(c_misalign), 64'd0);

        store(32'h104, W_WORD, 32'h0102_0304);
        store(32'h106, W_WORD, 32'hFFFF_FFFF);
        check("mis_word_pulse", 64'(c_misalign), 64'd1);
        load_chk("mis_word_ram", 32'h104, 32'h0102_0304);
        check("mis_word_clr", 64'(c_misalign), 64'd0);

        c_dmem_store     = 1'b1;
        dmem_store_addr  = 32'h100;
        dmem_store_width = W_WORD;
        dmem_store_data  = 32'hCAFE_F00D;
        c_dmem_load      = 1'b1;
        dmem_load_addr   = 32'h100;
        ld_q.push_back(32'hDE55_BEEF);
        @(negedge clk);
        check("rbw_old", 64'(dmem_load_data), 64'(ld_q.pop_front()));
        @(posedge clk);
        #1;
        c_dmem_store = 1'b0;
        c_dmem_load  = 1'b0;
        load_chk("rbw_new", 32'h100, 32'hCAFE_F00D);

        store(32'h100, 2'b11, 32'h0000_0000);
        store(32'h4000_0100, W_WORD, 32'h0BAD_0BAD);
        load_chk("w11_oob_st", 32'h100, 32'hCAFE_F00D);
        load_chk("oob_ld", 32'h4000_0100, 32'h0);
        load_chk("mmio_hole", MB + 32'h14, 32'h0);
        dmem_load_addr = 32'h100;
        @(negedge clk);
        check("ld_idle", 64'(dmem_load_data), 64'd0);
        @(posedge clk);
        #1;

        con_push(8'h41, 1'b0);
        con_push(8'h42, 1'b0);
        con_push(8'h43, 1'b0);
        con_push(8'h44, 1'b0);
        load_chk("stat_full", MB + 32'h4, 32'(m_cnt));
        check("ovf_full", 64'(c_con_ovf), 64'(m_ovf));
        con_push(8'h46, 1'b1);
        load_chk("stat_pp", MB + 32'h4, 32'(m_cnt));
        check("ovf_pp", 64'(c_con_ovf), 64'(m_ovf));
        con_push(8'h45, 1'b0);
        load_chk("stat_drop", MB + 32'h4, 32'(m_cnt));
        check("ovf_drop", 64'(c_con_ovf), 64'(m_ovf));
        drain("drain1");

        con_push(8'h47, 1'b1);
        check("empty_pp_valid", 64'(c_con_valid), 64'd1);
        check("empty_pp_data", 64'(con_data), 64'h47);
        drain("drain2");

        store(MB + 32'h8, W_WORD, 32'h0000_0007);
        check("halt_set", 64'(c_halt), 64'd1);
        check("exit_3", 64'(exit_code), 64'd3);
        store(MB + 32'h8, W_WORD, 32'h0000_0010);
        check("halt_sticky", 64'(c_halt), 64'd1);
        check("exit_8", 64'(exit_code), 64'd8);

        con_push(8'h50, 1'b0);
        c_srst = 1'b1;
        store(32'h300, W_WORD, 32'h5A5A_5A5A);
        c_srst = 1'b0;
        con_q.delete();
        m_cnt = 0;
        check("srst_halt", 64'(c_halt), 64'd0);
        check("srst_exit", 64'(exit_code), 64'd0);
        check("srst_ovf", 64'(c_con_ovf), 64'd0);
        check("srst_valid", 64'(c_con_valid), 64'd0);

`ifdef DMEM_CYCLE_CNT_EN
        load_chk("cyc_lo_0", MB + 32'hC, 32'd0);
        load_chk("cyc_lo_1", MB + 32'hC, 32'd1);
        load_chk("cyc_hi_0", MB + 32'h10, 32'd0);
`endif
        load_chk("srst_st_ram", 32'h300, 32'h5A5A_5A5A);

`ifdef DMEM_CYCLE_CNT_EN
        force dut.cyc_cnt = 64'h0000_0005_FFFF_FFFF;
        load_chk("cyc_lo_f5", MB + 32'hC, 32'hFFFF_FFFF);
        release dut.cyc_cnt;
        load_chk("cyc_hi_f5", MB + 32'h10, 32'h5);
        force dut.cyc_cnt = 64'h0000_0000_FFFF_FFFF;
        load_chk("cyc_lo_f0", MB + 32'hC, 32'hFFFF_FFFF);
        release dut.cyc_cnt;
        load_chk("cyc_hi_f0", MB + 32'h10, 32'h0);
`else
        repeat (3) @(posedge clk);
        #1;
        load_chk("cyc_lo_off", MB + 32'hC, 32'h0);
        load_chk("cyc_hi_off", MB + 32'h10, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
